// File: rtl/ex_mem_skid_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_stage_if : EX->MEM handshake and payload bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_mem_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic              in_mem_write;
  logic              in_mem_read;
  logic              in_branch;
  logic              in_zero;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_write_data;
  logic [REG_AW-1:0] in_write_reg;
  logic [PC_W-1:0]   in_branch_target;

  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic              out_mem_write;
  logic              out_mem_read;
  logic              out_branch;
  logic              out_zero;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_write_data;
  logic [REG_AW-1:0] out_write_reg;
  logic [PC_W-1:0]   out_branch_target;
  logic              out_branch_taken;

  // Environment view: drives the upstream beat, consumes the downstream one.
  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read,
           in_branch, in_zero, in_alu_result, in_write_data, in_write_reg,
           in_branch_target, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write,
           out_mem_read, out_branch, out_zero, out_alu_result, out_write_data,
           out_write_reg, out_branch_target, out_branch_taken
  );

  // Stage view.
  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read,
           in_branch, in_zero, in_alu_result, in_write_data, in_write_reg,
           in_branch_target, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write,
           out_mem_read, out_branch, out_zero, out_alu_result, out_write_data,
           out_write_reg, out_branch_target, out_branch_taken
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_skid_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_stage : EX/MEM pipeline stage with two-entry skid buffer,
// flush, gated control outputs and registered branch decision.
// Optional EX_MEM_PERF_EN adds saturating stall/flush counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush,
  ex_mem_skid_stage_if.slave    bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
`endif
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_read;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] write_reg;
    logic [PC_W-1:0]   branch_target;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  beat_t  r_main;
  beat_t  r_skid;
  logic   r_in_ready;
  logic   r_out_valid;

  beat_t  w_in_beat;
  logic   w_accept;
  logic   w_consume;

  assign w_in_beat = '{
    reg_write:     bus.in_reg_write,
    mem_to_reg:    bus.in_mem_to_reg,
    mem_write:     bus.in_mem_write,
    mem_read:      bus.in_mem_read,
    branch:        bus.in_branch,
    zero:          bus.in_zero,
    alu_result:    bus.in_alu_result,
    write_data:    bus.in_write_data,
    write_reg:     bus.in_write_reg,
    branch_target: bus.in_branch_target
  };

  assign w_accept  = bus.in_valid & r_in_ready & ~flush;
  assign w_consume = r_out_valid & bus.out_ready;

  // Handshake flags are registered alongside the state so neither ready nor
  // valid has a combinational path from any input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_in_beat;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_consume && w_accept) begin
            r_main <= w_in_beat;
          end else if (w_consume) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_skid     <= w_in_beat;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_consume) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready          = r_in_ready;
  assign bus.out_valid         = r_out_valid;
  assign bus.out_reg_write     = r_main.reg_write & r_out_valid;
  assign bus.out_mem_write     = r_main.mem_write & r_out_valid;
  assign bus.out_mem_read      = r_main.mem_read  & r_out_valid;
  assign bus.out_branch_taken  = r_out_valid & r_main.branch & r_main.zero;
  assign bus.out_mem_to_reg    = r_main.mem_to_reg;
  assign bus.out_branch        = r_main.branch;
  assign bus.out_zero          = r_main.zero;
  assign bus.out_alu_result    = r_main.alu_result;
  assign bus.out_write_data    = r_main.write_data;
  assign bus.out_write_reg     = r_main.write_reg;
  assign bus.out_branch_target = r_main.branch_target;

`ifdef EX_MEM_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_skid_stage : directed self-checking bench for ex_mem_skid_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_mem_skid_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  ex_mem_skid_stage_if #(.DATA_W(32), .REG_AW(5), .PC_W(8)) bus ();

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  ex_mem_skid_stage #(.DATA_W(32), .REG_AW(5), .PC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;        bus.in_reg_write = 1'b0;
    bus.in_mem_to_reg = 1'b0;   bus.in_mem_write = 1'b0;
    bus.in_mem_read = 1'b0;     bus.in_branch = 1'b0;
    bus.in_zero = 1'b0;         bus.in_alu_result = '0;
    bus.in_write_data = '0;     bus.in_write_reg = '0;
    bus.in_branch_target = '0;  bus.out_ready = 1'b0;

    // Reset and idle
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_alu", bus.out_alu_result, 32'd0);
    chk("rst_reg_write", 32'(bus.out_reg_write), 32'd0);
    chk("rst_target", 32'(bus.out_branch_target), 32'd0);
`ifdef EX_MEM_PERF_EN
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
`endif
    tick(); tick(); tick();
    chk("idle_mem_write", 32'(bus.out_mem_write), 32'd0);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Streaming with out_ready=1: each beat visible one cycle after accept
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_alu_result = 32'(i);
      tick();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_alu", bus.out_alu_result, 32'(i));
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: A in main, B in skid, C held upstream
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h10;
    tick();
    chk("bp_A_main", bus.out_alu_result, 32'h10);
    chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
    bus.in_alu_result = 32'h20;
    tick();
    chk("bp_ready_two", 32'(bus.in_ready), 32'd0);
    chk("bp_still_A", bus.out_alu_result, 32'h10);
    bus.in_alu_result = 32'h30;
    tick();
    chk("bp_C_held_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_C_held_alu", bus.out_alu_result, 32'h10);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out_B", bus.out_alu_result, 32'h20);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_out_C", bus.out_alu_result, 32'h30);
    chk("bp_C_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Flush while full, with a beat offered in the same cycle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h11; bus.in_mem_write = 1'b1;
    tick();
    chk("fl_memwr_valid", 32'(bus.out_mem_write), 32'd1);
    bus.in_alu_result = 32'h22; bus.in_mem_write = 1'b0;
    tick();
    chk("fl_two", 32'(bus.in_ready), 32'd0);
    flush = 1'b1; bus.in_alu_result = 32'h40;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_memwr_gated", 32'(bus.out_mem_write), 32'd0);
    chk("fl_alu_hold", bus.out_alu_result, 32'h11);
`ifdef EX_MEM_PERF_EN
    chk("fl_count", 32'(flush_count), 32'd1);
`endif
    tick();
    chk("fl_no_40", 32'(bus.out_valid), 32'd0);

    // Branch decision
    bus.in_valid = 1'b1; bus.in_branch = 1'b1; bus.in_zero = 1'b1;
    bus.in_branch_target = 8'hA5; bus.in_alu_result = 32'h50;
    tick();
    bus.in_valid = 1'b0;
    chk("br_taken", 32'(bus.out_branch_taken), 32'd1);
    chk("br_target", 32'(bus.out_branch_target), 32'hA5);
    bus.out_ready = 1'b1;
    tick();
    chk("br_gated_empty", 32'(bus.out_branch_taken), 32'd0);
    bus.in_valid = 1'b1; bus.in_zero = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("br_zero0_valid", 32'(bus.out_valid), 32'd1);
    chk("br_zero0_taken", 32'(bus.out_branch_taken), 32'd0);
    chk("br_zero0_target", 32'(bus.out_branch_target), 32'hA5);
    tick();
    bus.in_branch = 1'b0;

`ifdef EX_MEM_PERF_EN
    // Saturate the stall counter
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h77;
    tick();
    bus.in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_count), 32'hFFFF);
`endif

    // Reset applied mid-operation with both entries full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_alu_result = 32'h61;
    tick();
    bus.in_alu_result = 32'h62;
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_alu", bus.out_alu_result, 32'd0);
`ifdef EX_MEM_PERF_EN
    chk("midrst_stall_cnt", 32'(stall_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised EX/MEM pipeline stage between the execute and memory stages. It adds a two-entry skid buffer with valid/ready handshake on both sides, flush (squash) support, and gated control outputs so that bubbles never write memory or registers. It also produces a registered branch-taken decision. Payload widths are parameters, so one module serves the 32-bit core and narrower test configurations.

## Interface
- `DATA_W`, 32, width of the ALU result and store-data fields
- `REG_AW`, 5, destination register index width
- `PC_W`, 8, branch target width (full width kept, no truncation)
- `clk` input 1: clock
- `reset` input 1: reset, synchronous, active-high
- `flush` input 1: squash every buffered entry and any beat offered this cycle
- `in_valid` input 1: upstream beat valid
- `in_ready` output 1: stage can accept a beat
- `in_reg_write`, `in_mem_to_reg`, `in_mem_write`, `in_mem_read`, `in_branch`, `in_zero` input 1 each: control and flag fields
- `in_alu_result` input DATA_W; `in_write_data` input DATA_W; `in_write_reg` input REG_AW; `in_branch_target` input PC_W
- `out_valid` output 1: main entry holds a beat
- `out_ready` input 1: downstream consumes the main entry
- `out_reg_write`, `out_mem_to_reg`, `out_mem_write`, `out_mem_read`, `out_branch`, `out_zero` output 1 each
- `out_alu_result` DATA_W; `out_write_data` DATA_W; `out_write_reg` REG_AW; `out_branch_target` PC_W: outputs
- `out_branch_taken` output 1: out_valid & out_branch & out_zero
- `stall_count` output 16, `flush_count` output 16: present only with EX_MEM_PERF_EN

## Operation
- Storage: main register (drives outputs) and skid register. States: EMPTY, ONE, TWO.
- `in_ready` = (state != TWO). `out_valid` = (state != EMPTY). Both are decoded from the state, never from inputs.
- Accept = in_valid & in_ready & !flush. Consume = out_valid & out_ready.
- EMPTY: accept → main ← in, go to ONE.
- ONE, consume & accept → main ← in, stay in ONE.
- ONE, consume & no accept → EMPTY.
- ONE, no consume & accept → skid ← in, go to TWO.
- ONE, no consume & no accept → hold.
- TWO, consume → main ← skid, go to ONE. in_valid is ignored because in_ready=0.
- TWO, no consume → hold.
- Flush has priority: next state is EMPTY and the offered beat is dropped. A consume in the same cycle still counts as delivered.
- Gating: out_reg_write, out_mem_write, out_mem_read and out_branch_taken are ANDed with out_valid.
- Ungated payload fields hold their last value in EMPTY. They are 0 after reset.
- The beat order is strictly FIFO and no beat is duplicated.

## Timing
- Reset values: state EMPTY; out_valid 0; in_ready 1; all payload and control outputs 0; counters 0.
- Reset applied mid-operation discards both entries on the next edge.
- Latency: a beat accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready falls one cycle after the first unconsumed accept (entry into TWO), so the upstream may present one extra beat with no combinational ready path.
- No combinational path from any input to in_ready or out_valid. out_branch_taken is combinational from registers only.

## Configuration
- `EX_MEM_PERF_EN` defined:
  - stall_count increments on cycles with out_valid & !out_ready.
  - flush_count increments on cycles where flush=1 and state != EMPTY.
  - Both counters saturate at 16'hFFFF and clear on reset.
- `EX_MEM_PERF_EN` undefined: both ports and counters are absent, and datapath behaviour is identical.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, all outputs 0. After 3 cycles, out_mem_write is still 0.
- Stream beats with alu_result 1..8, out_ready=1: outputs 1..8 on consecutive cycles, each one cycle after its accept, and in_ready stays 1.
- Offer 3 beats (A=0x10, B=0x20, C=0x30) with out_ready=0: A in main, B in skid, in_ready=0 on the third cycle, C held upstream. Raise out_ready: outputs A, B, C in order with none lost.
- In TWO, assert flush together with in_valid (0x40): next cycle out_valid=0, in_ready=1, 0x40 never appears. With EX_MEM_PERF_EN, flush_count=1.
- Beat with branch=1, zero=1, target=0xA5: out_branch_taken=1 and out_branch_target=0xA5. The same beat with zero=0 gives out_branch_taken=0.
- With EX_MEM_PERF_EN, hold out_ready=0 for 70000 cycles with a valid beat: stall_count saturates at 0xFFFF. Assert reset: stall_count=0 and out_valid=0.
